// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: arbitrates exception and return requests,
// drains the memory stage, writes EPC/Cause/EXL and redirects the PC.
module exc_ctrl #(
  parameter logic [29:0] VEC_ADDR  = 30'h20000060,
  parameter int unsigned DRAIN_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ov_req,
  input  logic        syscall_req,
  input  logic        eret_req,
  input  logic [5:0]  ext_int,
  input  logic [5:0]  int_mask,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [29:0] req_pc,
  input  logic [29:0] epc_in,
  input  logic        pipe_busy,
  output logic        flush,
  output logic        pc_sel,
  output logic [29:0] pc_target,
  output logic        epc_we,
  output logic [29:0] epc_data,
  output logic        cause_we,
  output logic [4:0]  exc_code,
  output logic        exl_set,
  output logic        exl_clr,
  output logic        busy,
  output logic        drain_to
);

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_OV  = 5'd12;
  localparam logic [3:0] DRAIN_LIM = 4'(DRAIN_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_SAVE   = 3'd2,
    S_VECTOR = 3'd3,
    S_RETURN = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic [29:0] pc_cap_q, pc_cap_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        drain_to_q, drain_to_d;

  logic        int_pend_s;
  logic [3:0]  cnt_inc_s;

  logic        flush_q, flush_d;
  logic        pc_sel_q, pc_sel_d;
  logic [29:0] pc_target_q, pc_target_d;
  logic        epc_we_q, epc_we_d;
  logic [29:0] epc_data_q, epc_data_d;
  logic        cause_we_q, cause_we_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic        exl_set_q, exl_set_d;
  logic        exl_clr_q, exl_clr_d;
  logic        busy_q, busy_d;

  assign int_pend_s = status_ie & ~status_exl & (|(ext_int & int_mask));
  assign cnt_inc_s  = cnt_q + 4'd1;

  // Next-state, capture and drain-counter logic; arbitration only in IDLE.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    pc_cap_d   = pc_cap_q;
    cnt_d      = cnt_q;
    drain_to_d = drain_to_q;
    case (state_q)
      S_IDLE: begin
        if (ov_req) begin
          code_d   = EXC_OV;
          pc_cap_d = req_pc;
          cnt_d    = 4'd0;
          state_d  = S_DRAIN;
        end else if (syscall_req) begin
          code_d   = EXC_SYS;
          pc_cap_d = req_pc;
          cnt_d    = 4'd0;
          state_d  = S_DRAIN;
        end else if (int_pend_s) begin
          code_d   = EXC_INT;
          pc_cap_d = req_pc;
          cnt_d    = 4'd0;
          state_d  = S_DRAIN;
        end else if (eret_req) begin
          pc_cap_d = epc_in;
          state_d  = S_RETURN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_inc_s;
        if (!pipe_busy) begin
          state_d = S_SAVE;
        end else if (cnt_inc_s == DRAIN_LIM) begin
          // Memory stage never went quiet: proceed anyway and flag it.
          state_d    = S_SAVE;
          drain_to_d = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_SAVE:   state_d = S_VECTOR;
      S_VECTOR: state_d = S_IDLE;
      S_RETURN: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe.
  always_comb begin
    flush_d     = 1'b0;
    pc_sel_d    = 1'b0;
    pc_target_d = 30'd0;
    epc_we_d    = 1'b0;
    epc_data_d  = 30'd0;
    cause_we_d  = 1'b0;
    exc_code_d  = 5'd0;
    exl_set_d   = 1'b0;
    exl_clr_d   = 1'b0;
    busy_d      = 1'b0;
    case (state_d)
      S_IDLE: begin
        busy_d = 1'b0;
      end
      S_DRAIN: begin
        flush_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_SAVE: begin
        flush_d    = 1'b1;
        busy_d     = 1'b1;
        epc_we_d   = 1'b1;
        epc_data_d = pc_cap_d;
        cause_we_d = 1'b1;
        exc_code_d = code_d;
        exl_set_d  = 1'b1;
      end
      S_VECTOR: begin
        flush_d     = 1'b1;
        busy_d      = 1'b1;
        pc_sel_d    = 1'b1;
        pc_target_d = VEC_ADDR;
      end
      S_RETURN: begin
        flush_d     = 1'b1;
        busy_d      = 1'b1;
        pc_sel_d    = 1'b1;
        exl_clr_d   = 1'b1;
        pc_target_d = pc_cap_d;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, capture and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      code_q     <= 5'd0;
      pc_cap_q   <= 30'd0;
      cnt_q      <= 4'd0;
      drain_to_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      pc_cap_q   <= pc_cap_d;
      cnt_q      <= cnt_d;
      drain_to_q <= drain_to_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q     <= 1'b0;
      pc_sel_q    <= 1'b0;
      pc_target_q <= 30'd0;
      epc_we_q    <= 1'b0;
      epc_data_q  <= 30'd0;
      cause_we_q  <= 1'b0;
      exc_code_q  <= 5'd0;
      exl_set_q   <= 1'b0;
      exl_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      flush_q     <= flush_d;
      pc_sel_q    <= pc_sel_d;
      pc_target_q <= pc_target_d;
      epc_we_q    <= epc_we_d;
      epc_data_q  <= epc_data_d;
      cause_we_q  <= cause_we_d;
      exc_code_q  <= exc_code_d;
      exl_set_q   <= exl_set_d;
      exl_clr_q   <= exl_clr_d;
      busy_q      <= busy_d;
    end
  end

  assign flush     = flush_q;
  assign pc_sel    = pc_sel_q;
  assign pc_target = pc_target_q;
  assign epc_we    = epc_we_q;
  assign epc_data  = epc_data_q;
  assign cause_we  = cause_we_q;
  assign exc_code  = exc_code_q;
  assign exl_set   = exl_set_q;
  assign exl_clr   = exl_clr_q;
  assign busy      = busy_q;
  assign drain_to  = drain_to_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Testbench for exc_ctrl: table of request scenarios expanded into per-cycle
// expected outputs on a scoreboard queue, plus a hand-written reset sequence.
module tb_exc_ctrl;

  localparam logic [29:0] VEC = 30'h20000060;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ov_req = 1'b0, syscall_req = 1'b0, eret_req = 1'b0;
  logic [5:0]  ext_int = 6'd0, int_mask = 6'd0;
  logic        status_ie = 1'b0, status_exl = 1'b0;
  logic [29:0] req_pc = 30'd0, epc_in = 30'd0;
  logic        pipe_busy = 1'b0;
  logic        flush, pc_sel, epc_we, cause_we, exl_set, exl_clr, busy, drain_to;
  logic [29:0] pc_target, epc_data;
  logic [4:0]  exc_code;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ov_req(ov_req), .syscall_req(syscall_req),
    .eret_req(eret_req), .ext_int(ext_int), .int_mask(int_mask),
    .status_ie(status_ie), .status_exl(status_exl), .req_pc(req_pc),
    .epc_in(epc_in), .pipe_busy(pipe_busy), .flush(flush), .pc_sel(pc_sel),
    .pc_target(pc_target), .epc_we(epc_we), .epc_data(epc_data),
    .cause_we(cause_we), .exc_code(exc_code), .exl_set(exl_set),
    .exl_clr(exl_clr), .busy(busy), .drain_to(drain_to)
  );

  typedef struct packed {
    logic        flush;
    logic        pc_sel;
    logic [29:0] pc_target;
    logic        epc_we;
    logic [29:0] epc_data;
    logic        cause_we;
    logic [4:0]  exc_code;
    logic        exl_set;
    logic        exl_clr;
    logic        busy;
    logic        drain_to;
  } out_t;

  typedef struct {
    string       name;
    logic        ov, sys, eret;
    logic [5:0]  ext, mask;
    logic        ie, exl;
    logic [29:0] pc, epc;
    int          bcy;
    logic        noise;
  } vec_t;

  out_t exp_q[$];
  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_dto = 1'b0;

  // st: 0 idle, 1 drain, 2 save, 3 vector, 4 return
  function automatic out_t o_st(input int st, input logic [29:0] a, input logic [4:0] c);
    out_t o;
    o = '0;
    o.drain_to = exp_dto;
    case (st)
      1: begin o.flush = 1'b1; o.busy = 1'b1; end
      2: begin
        o.flush = 1'b1; o.busy = 1'b1; o.epc_we = 1'b1; o.epc_data = a;
        o.cause_we = 1'b1; o.exc_code = c; o.exl_set = 1'b1;
      end
      3: begin o.flush = 1'b1; o.busy = 1'b1; o.pc_sel = 1'b1; o.pc_target = VEC; end
      4: begin
        o.flush = 1'b1; o.busy = 1'b1; o.pc_sel = 1'b1; o.exl_clr = 1'b1;
        o.pc_target = a;
      end
      default: ;
    endcase
    return o;
  endfunction

  function automatic out_t got_now();
    out_t g;
    g.flush = flush; g.pc_sel = pc_sel; g.pc_target = pc_target;
    g.epc_we = epc_we; g.epc_data = epc_data; g.cause_we = cause_we;
    g.exc_code = exc_code; g.exl_set = exl_set; g.exl_clr = exl_clr;
    g.busy = busy; g.drain_to = drain_to;
    return g;
  endfunction

  task automatic check(input string tag, input int idx);
    out_t e, g;
    e = exp_q.pop_front();
    g = got_now();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s[cycle %0d]: got %h required %h (flush %b/%b pc_sel %b/%b tgt %h/%h epc_we %b/%b code %0d/%0d exl_set %b/%b exl_clr %b/%b dto %b/%b)",
               tag, idx, g, e, g.flush, e.flush, g.pc_sel, e.pc_sel, g.pc_target, e.pc_target,
               g.epc_we, e.epc_we, g.exc_code, e.exc_code, g.exl_set, e.exl_set,
               g.exl_clr, e.exl_clr, g.drain_to, e.drain_to);
    end
  endtask

  task automatic add_vec(input string nm, input logic ov, input logic sys, input logic er,
                         input logic [5:0] ext, input logic [5:0] mask, input logic ie,
                         input logic exl, input logic [29:0] pc, input logic [29:0] epc,
                         input int bcy, input logic noise);
    vec_t v;
    v.name = nm; v.ov = ov; v.sys = sys; v.eret = er; v.ext = ext; v.mask = mask;
    v.ie = ie; v.exl = exl; v.pc = pc; v.epc = epc; v.bcy = bcy; v.noise = noise;
    vq.push_back(v);
  endtask

  // Reference model: expected output for every cycle of one scenario.
  task automatic build(input vec_t v, output int n);
    logic       pend, exc;
    logic [4:0] code;
    int         d;
    pend = v.ie & ~v.exl & (|(v.ext & v.mask));
    exc  = v.ov | v.sys | pend;
    code = v.ov ? 5'd12 : (v.sys ? 5'd8 : 5'd0);
    exp_q.push_back(o_st(0, 30'd0, 5'd0));
    if (exc) begin
      d = (v.bcy >= 15) ? 15 : v.bcy + 1;
      for (int i = 0; i < d; i++) exp_q.push_back(o_st(1, 30'd0, 5'd0));
      if (v.bcy >= 15) exp_dto = 1'b1;
      exp_q.push_back(o_st(2, v.pc, code));
      exp_q.push_back(o_st(3, 30'd0, 5'd0));
    end else if (v.eret) begin
      exp_q.push_back(o_st(4, v.epc, 5'd0));
    end
    exp_q.push_back(o_st(0, 30'd0, 5'd0));
    n = exp_q.size();
  endtask

  task automatic clear_inputs();
    ov_req = 1'b0; syscall_req = 1'b0; eret_req = 1'b0;
    ext_int = 6'd0; int_mask = 6'd0; status_ie = 1'b0; status_exl = 1'b0;
    req_pc = 30'd0; epc_in = 30'd0;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    build(v, n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(v.name, i);
      if (i == 0) begin
        ov_req = v.ov; syscall_req = v.sys; eret_req = v.eret;
        ext_int = v.ext; int_mask = v.mask; status_ie = v.ie; status_exl = v.exl;
        req_pc = v.pc; epc_in = v.epc;
      end else if (v.noise && i < n - 1) begin
        // Requests arriving while busy must be ignored.
        ov_req = 1'b1; syscall_req = 1'b1; eret_req = 1'b1;
        ext_int = 6'h3F; int_mask = 6'h3F; status_ie = 1'b1; status_exl = 1'b0;
        req_pc = ~v.pc; epc_in = ~v.epc;
      end else begin
        clear_inputs();
      end
      pipe_busy = (i >= 1 && i <= v.bcy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    add_vec("sys_basic",   1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 30'h100, 30'd0, 0, 1'b0);
    add_vec("all_three",   1'b1, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 30'h55, 30'h77, 0, 1'b0);
    add_vec("int_exl_blk", 1'b0, 1'b0, 1'b0, 6'b000100, 6'b000100, 1'b1, 1'b1, 30'h200, 30'd0, 0, 1'b0);
    add_vec("int_ok",      1'b0, 1'b0, 1'b0, 6'b000100, 6'b000100, 1'b1, 1'b0, 30'h200, 30'd0, 0, 1'b0);
    add_vec("eret",        1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 30'h0, 30'h2A, 0, 1'b0);
    add_vec("ov_drain3",   1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 30'h3FFFFFFF, 30'd0, 3, 1'b0);
    add_vec("int_masked",  1'b0, 1'b0, 1'b0, 6'b000100, 6'b111011, 1'b1, 1'b0, 30'h300, 30'd0, 0, 1'b0);
    add_vec("sys_vs_int",  1'b0, 1'b1, 1'b0, 6'b100000, 6'b100000, 1'b1, 1'b0, 30'h404, 30'd0, 0, 1'b0);
    add_vec("int_vs_eret", 1'b0, 1'b0, 1'b1, 6'b000001, 6'b000001, 1'b1, 1'b0, 30'h508, 30'h99, 1, 1'b0);
    add_vec("int_ie_off",  1'b0, 1'b0, 1'b0, 6'h3F, 6'h3F, 1'b0, 1'b0, 30'h600, 30'd0, 0, 1'b0);
    add_vec("sys_noise",   1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 30'h1234, 30'd0, 2, 1'b1);
    add_vec("eret_noise",  1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 30'h0, 30'h0ABCDE, 0, 1'b1);
    add_vec("drain_tmo",   1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 30'h0C0, 30'd0, 20, 1'b0);
    add_vec("eret_sticky", 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 30'h0, 30'h1F, 0, 1'b0);

    // Reset state
    clear_inputs();
    rst_n = 1'b0;
    pipe_busy = 1'b0;
    @(negedge clk);
    exp_q.push_back(o_st(0, 30'd0, 5'd0));
    check("reset", 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[k]) run_vec(vq[k]);

    // Reset asserted while in SAVE, then arbitration right after release.
    @(negedge clk);
    exp_q.push_back(o_st(0, 30'd0, 5'd0)); check("rs_idle", 0);
    syscall_req = 1'b1; req_pc = 30'h77; pipe_busy = 1'b0;
    @(negedge clk);
    exp_q.push_back(o_st(1, 30'd0, 5'd0)); check("rs_drain", 1);
    clear_inputs();
    @(negedge clk);
    exp_q.push_back(o_st(2, 30'h77, 5'd8)); check("rs_save", 2);
    #1 rst_n = 1'b0;
    #1;
    exp_dto = 1'b0;
    exp_q.push_back(o_st(0, 30'd0, 5'd0)); check("rs_async_clr", 3);
    @(negedge clk);
    exp_q.push_back(o_st(0, 30'd0, 5'd0)); check("rs_held", 4);
    rst_n = 1'b1; syscall_req = 1'b1; req_pc = 30'h99;
    @(negedge clk);
    exp_q.push_back(o_st(1, 30'd0, 5'd0)); check("rs_resume", 5);
    clear_inputs();
    @(negedge clk);
    exp_q.push_back(o_st(2, 30'h99, 5'd8)); check("rs_save2", 6);
    @(negedge clk);
    exp_q.push_back(o_st(3, 30'd0, 5'd0)); check("rs_vector", 7);
    @(negedge clk);
    exp_q.push_back(o_st(0, 30'd0, 5'd0)); check("rs_done", 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
